// File: rtl/boid_pkg.sv
// boid_pkg: shared constants, position/state types and framebuffer address helper for the boid writer.
package boid_pkg;
  localparam int VIDEO_WIDTH = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int PIXEL_ADDRESS_WIDTH = 20;
  localparam int NUM_BOIDS = 32;
  localparam int BOX_SIZE = 2;
  localparam int IDX_W = $clog2(NUM_BOIDS);
  localparam int BOX_W = BOX_SIZE > 1 ? $clog2(BOX_SIZE) : 1;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } boid_pos_t;
  typedef enum logic [2:0] {IDLE, ERASE, FETCH, CAPTURE, DRAW, DONE} state_t;
  // y*640 as (y<<9)+(y<<7), avoiding a multiplier
  function automatic logic [PIXEL_ADDRESS_WIDTH-1:0] pix_addr(input logic [10:0] px, input logic [9:0] py);
    return (PIXEL_ADDRESS_WIDTH'(py) << 9) + (PIXEL_ADDRESS_WIDTH'(py) << 7) + PIXEL_ADDRESS_WIDTH'(px);
  endfunction
endpackage

// File: rtl/box_scanner.sv
// box_scanner: walks a BOX_SIZE x BOX_SIZE box (dy outer, dx inner), clips each pixel and forms its address.
module box_scanner import boid_pkg::*; (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  boid_pos_t                      base,
  output logic                           last,
  output logic                           in_range,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] addr
);
  localparam logic [BOX_W-1:0] MAX = BOX_W'(BOX_SIZE - 1);
  logic [BOX_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [10:0] px;
  logic [9:0] py;
  always_comb begin
    last = dx_q == MAX && dy_q == MAX;
    dx_d = !en ? dx_q : dx_q == MAX ? '0 : dx_q + 1'b1;
    dy_d = !en || dx_q != MAX ? dy_q : dy_q == MAX ? '0 : dy_q + 1'b1;
    px = {1'b0, base.x} + 11'(dx_q);
    py = {1'b0, base.y} + 10'(dy_q);
    in_range = px < 11'(VIDEO_WIDTH) && py < 10'(VIDEO_HEIGHT);
    addr = pix_addr(px, py);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
endmodule

// File: rtl/boid_frame_writer.sv
// boid_frame_writer: once per frame erases each boid's previous box and draws its new one into the 1-bit framebuffer.
module boid_frame_writer import boid_pkg::*; (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           screenEnd,
  output logic [IDX_W-1:0]               boid_index,
  input  logic [9:0]                     boid_x,
  input  logic [8:0]                     boid_y,
  output logic                           pix_wr_en,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] pix_wr_addr,
  output logic                           pix_wr_data,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           frame_dropped
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, boid_index_q, boid_index_d;
  logic screen_end_q, start;
  logic [NUM_BOIDS-1:0] valid_q, valid_d;
  boid_pos_t pos_q [NUM_BOIDS];
  boid_pos_t pos_d [NUM_BOIDS];
  logic pix_wr_en_q, pix_wr_en_d, pix_wr_data_q, pix_wr_data_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0] pix_wr_addr_q, pix_wr_addr_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d, frame_dropped_q, frame_dropped_d;
  logic scan_en, scan_last, scan_in_range;
  logic [PIXEL_ADDRESS_WIDTH-1:0] scan_addr;
  // ERASE reads the old entry before CAPTURE overwrites it, so both phases share table[i]
  box_scanner u_scan (
    .clk      (clk),
    .reset    (reset),
    .en       (scan_en),
    .base     (pos_q[i_q]),
    .last     (scan_last),
    .in_range (scan_in_range),
    .addr     (scan_addr)
  );
  always_comb begin
    start = screenEnd & ~screen_end_q;
    scan_en = state_q == ERASE || state_q == DRAW;
    state_d = state_q;
    i_d = i_q;
    boid_index_d = boid_index_q;
    valid_d = valid_q;
    pos_d = pos_q;
    case (state_q)
      IDLE: begin
        state_d = start ? ERASE : IDLE;
        i_d = start ? '0 : i_q;
      end
      ERASE: begin
        state_d = scan_last ? FETCH : ERASE;
        boid_index_d = scan_last ? i_q : boid_index_q;
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        state_d = DRAW;
        valid_d[i_q] = 1'b1;
        pos_d[i_q] = '{x: boid_x, y: boid_y};
      end
      DRAW: begin
        state_d = !scan_last ? DRAW : i_q == IDX_W'(NUM_BOIDS - 1) ? DONE : ERASE;
        i_d = scan_last && i_q != IDX_W'(NUM_BOIDS - 1) ? i_q + 1'b1 : i_q;
      end
      default: state_d = IDLE;
    endcase
    pix_wr_en_d = ((state_q == ERASE && valid_q[i_q]) || state_q == DRAW) && scan_in_range;
    pix_wr_data_d = state_q == DRAW;
    pix_wr_addr_d = scan_addr;
    busy_d = state_d != IDLE;
    frame_done_d = state_d == DONE;
    frame_dropped_d = start && state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q <= '0;
      boid_index_q <= '0;
      screen_end_q <= 1'b0;
      valid_q <= '0;
      pix_wr_en_q <= 1'b0;
      pix_wr_data_q <= 1'b0;
      pix_wr_addr_q <= '0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      boid_index_q <= boid_index_d;
      screen_end_q <= screenEnd;
      valid_q <= valid_d;
      pix_wr_en_q <= pix_wr_en_d;
      pix_wr_data_q <= pix_wr_data_d;
      pix_wr_addr_q <= pix_wr_addr_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
      frame_dropped_q <= frame_dropped_d;
    end
    pos_q <= pos_d;
  end
  assign boid_index = boid_index_q;
  assign pix_wr_en = pix_wr_en_q;
  assign pix_wr_addr = pix_wr_addr_q;
  assign pix_wr_data = pix_wr_data_q;
  assign busy = busy_q;
  assign frame_done = frame_done_q;
  assign frame_dropped = frame_dropped_q;
endmodule

// File: tb/tb_boid_frame_writer.sv
// tb_boid_frame_writer: table of whole-frame scenarios with hand-computed write logs and timing.
module tb_boid_frame_writer;
  import boid_pkg::*;
  logic clk = 1'b0;
  logic reset, screenEnd;
  logic [IDX_W-1:0] boid_index;
  logic [9:0] boid_x;
  logic [8:0] boid_y;
  logic pix_wr_en, pix_wr_data, busy, frame_done, frame_dropped;
  logic [PIXEL_ADDRESS_WIDTH-1:0] pix_wr_addr;
  boid_frame_writer dut (
    .clk           (clk),
    .reset         (reset),
    .screenEnd     (screenEnd),
    .boid_index    (boid_index),
    .boid_x        (boid_x),
    .boid_y        (boid_y),
    .pix_wr_en     (pix_wr_en),
    .pix_wr_addr   (pix_wr_addr),
    .pix_wr_data   (pix_wr_data),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_dropped (frame_dropped)
  );
  always #5 clk = ~clk;
  logic [9:0] mem_x [NUM_BOIDS];
  logic [8:0] mem_y [NUM_BOIDS];
  always @(posedge clk) begin
    boid_x <= mem_x[boid_index];
    boid_y <= mem_y[boid_index];
  end
  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    int drop_at;
    int reset_at;
    int first_n;
    int n_exp;
    int drops_exp;
    logic [7:0][19:0] a;
    logic [7:0] d;
  } vec_t;
  vec_t v [6];
  int checks = 0, fails = 0;
  logic [19:0] wa [$];
  logic wd [$];
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic setv(input int k, input int x, input int y, input int drop_at, input int reset_at,
                      input int first_n, input int n_exp, input int drops_exp);
    v[k].x = 10'(x);
    v[k].y = 9'(y);
    v[k].drop_at = drop_at;
    v[k].reset_at = reset_at;
    v[k].first_n = first_n;
    v[k].n_exp = n_exp;
    v[k].drops_exp = drops_exp;
    v[k].a = '0;
    v[k].d = '0;
  endtask
  task automatic setw(input int k, input int j, input int a, input bit d);
    v[k].a[j] = 20'(a);
    v[k].d[j] = d;
  endtask
  initial begin
    int done_n, dones, drops, drop_n, first;
    setv(0, 10, 20, -10, -10, 8, 4, 0);
    setw(0, 0, 12810, 1); setw(0, 1, 12811, 1); setw(0, 2, 13450, 1); setw(0, 3, 13451, 1);
    setv(1, 11, 20, -10, -10, 2, 8, 0);
    setw(1, 0, 12810, 0); setw(1, 1, 12811, 0); setw(1, 2, 13450, 0); setw(1, 3, 13451, 0);
    setw(1, 4, 12811, 1); setw(1, 5, 12812, 1); setw(1, 6, 13451, 1); setw(1, 7, 13452, 1);
    setv(2, 639, 479, -10, -10, 2, 5, 0);
    setw(2, 0, 12811, 0); setw(2, 1, 12812, 0); setw(2, 2, 13451, 0); setw(2, 3, 13452, 0);
    setw(2, 4, 307199, 1);
    setv(3, 639, 479, 100, -10, 2, 2, 1);
    setw(3, 0, 307199, 0); setw(3, 1, 307199, 1);
    setv(4, 639, 479, -10, 50, -1, -1, 0);
    setv(5, 100, 100, -10, -10, 8, 4, 0);
    setw(5, 0, 64100, 1); setw(5, 1, 64101, 1); setw(5, 2, 64740, 1); setw(5, 3, 64741, 1);
    for (int b = 0; b < NUM_BOIDS; b++) begin
      mem_x[b] = 10'd700;
      mem_y[b] = 9'd500;
    end
    reset = 1'b1;
    screenEnd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", pix_wr_en, 0);
    chk("rst_wr_addr", pix_wr_addr, 0);
    chk("rst_wr_data", pix_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_dropped", frame_dropped, 0);
    chk("rst_index", boid_index, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      mem_x[0] = v[k].x;
      mem_y[0] = v[k].y;
      wa.delete();
      wd.delete();
      done_n = -1; dones = 0; drops = 0; drop_n = -1; first = -1;
      @(posedge clk);
      #1 screenEnd = 1'b1;
      for (int n = 1; n <= 335; n++) begin
        @(posedge clk);
        #1;
        if (n == 4 || n == v[k].drop_at + 2) screenEnd = 1'b0;
        if (n == v[k].drop_at) screenEnd = 1'b1;
        if (n == v[k].reset_at) reset = 1'b1;
        @(negedge clk);
        if (pix_wr_en) begin
          if (first < 0) first = n;
          wa.push_back(pix_wr_addr);
          wd.push_back(pix_wr_data);
        end
        if (frame_done) begin dones++; done_n = n; end
        if (frame_dropped) begin drops++; drop_n = n; end
        if (n == 1) chk($sformatf("v%0d_busy_start", k), busy, 1);
        if (n == 321) chk($sformatf("v%0d_busy_done_cycle", k), busy, 1);
        if (n == 322) chk($sformatf("v%0d_busy_after", k), busy, 0);
        if (n == v[k].reset_at + 1) begin
          chk($sformatf("v%0d_reset_wr_en", k), pix_wr_en, 0);
          chk($sformatf("v%0d_reset_busy", k), busy, 0);
          reset = 1'b0;
          break;
        end
      end
      if (v[k].reset_at < 0) begin
        chk($sformatf("v%0d_done_cycle", k), done_n, 321);
        chk($sformatf("v%0d_done_count", k), dones, 1);
        chk($sformatf("v%0d_drop_count", k), drops, v[k].drops_exp);
        if (v[k].drops_exp > 0) chk($sformatf("v%0d_drop_cycle", k), drop_n, v[k].drop_at + 1);
        chk($sformatf("v%0d_busy_end", k), busy, 0);
        chk($sformatf("v%0d_first_write", k), first, v[k].first_n);
        chk($sformatf("v%0d_num_writes", k), wa.size(), v[k].n_exp);
        for (int j = 0; j < v[k].n_exp && j < wa.size(); j++) begin
          chk($sformatf("v%0d_w%0d_addr", k, j), wa[j], v[k].a[j]);
          chk($sformatf("v%0d_w%0d_data", k, j), wd[j], v[k].d[j]);
        end
      end
      repeat (4) @(posedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/boid_frame_writer.md
Name: boid_frame_writer

Overview:
- Upstream neighbour of the VGA display stage.
- Rebuilds the 1-bit boid framebuffer once per frame: on each screenEnd it erases every boid's previous box, fetches the new position from boid state memory, and draws the new box.
- Its write port drives the framebuffer's write side; the VGA controller reads the other side.

Parameters:
- NUM_BOIDS, 32, number of boids per frame; indices 0..NUM_BOIDS-1.
- BOX_SIZE, 2, side in pixels of the square drawn per boid, anchored top-left at (x,y).
- VIDEO_WIDTH, 640, visible width.
- VIDEO_HEIGHT, 480, visible height.
- PIXEL_ADDRESS_WIDTH, 20, framebuffer address width, equal to $clog2(640*480)+1.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- screenEnd  in  1  frame-boundary flag from the timing generator; may stay high for several clk cycles.
- boid_index  out  $clog2(NUM_BOIDS)  read address into boid state memory.
- boid_x  in  10  x of boid_index; valid exactly 1 cycle after boid_index changes.
- boid_y  in  9  y of boid_index; same timing as boid_x.
- pix_wr_en  out  1  framebuffer write strobe.
- pix_wr_addr  out  PIXEL_ADDRESS_WIDTH  write address, x + 640*y.
- pix_wr_data  out  1  1 = boid, 0 = background.
- busy  out  1  high from frame start until the DONE cycle inclusive.
- frame_done  out  1  one-cycle pulse when all boids are drawn.
- frame_dropped  out  1  one-cycle pulse when a frame start arrives while busy.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- All outputs are registered. Reset values:
  - pix_wr_en, pix_wr_addr, pix_wr_data, busy, frame_done, frame_dropped, boid_index = 0.
  - State = IDLE. All old-position valid bits cleared.
- Frame start:
  - screenEnd is registered into screenEnd_d.
  - start = screenEnd & ~screenEnd_d, one pulse per frame regardless of how long screenEnd stays high.
- Old-position table: NUM_BOIDS entries of {valid, x[9:0], y[8:0]}, held internally.
- FSM:
  - IDLE: on start, set i=0, busy=1, go to ERASE.
  - ERASE: exactly BOX_SIZE² cycles scanning dy outer, dx inner.
    - Each cycle: pix_wr_en = valid[i] & in_range, pix_wr_data = 0, address from the old (x,y) of entry i.
    - On exit, drive boid_index=i and go to FETCH.
  - FETCH: 1 cycle while the memory responds.
  - CAPTURE: latch boid_x/boid_y, write them into table[i] with valid=1, go to DRAW.
  - DRAW: BOX_SIZE² cycles, same scan order, pix_wr_data=1, address from the new position.
    - If i==NUM_BOIDS-1 go to DONE; otherwise i++ and go to ERASE.
  - DONE: frame_done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Timing:
  - Per-boid cost is 2·BOX_SIZE²+2 cycles.
  - Frame cost is NUM_BOIDS·(2·BOX_SIZE²+2)+1 cycles: 321 with defaults.
  - First write appears 2 cycles after the clk edge where screenEnd first rises (edge detect, then ERASE).
- Clipping: per pixel. Write only if x+dx < VIDEO_WIDTH and y+dy < VIDEO_HEIGHT, compared in 11/10-bit arithmetic with no wrap. Clipped cycles still consume their slot with pix_wr_en=0.
- Address arithmetic: (y+dy)*640 + (x+dx), computed at PIXEL_ADDRESS_WIDTH bits. Multiply by 640 is implemented as (y<<9)+(y<<7).
- start while busy: ignored; frame_dropped pulses that same cycle; the current frame continues.
- start in the DONE cycle: counts as busy, so it is dropped.
- Reset mid-frame: pix_wr_en drops next cycle and valid bits clear. The framebuffer may then hold stale pixels; the system reset is expected to clear it.
- boid_index holds its value outside FETCH/CAPTURE.

Decomposition:
- Package boid_pkg:
  - VIDEO_WIDTH, VIDEO_HEIGHT, PIXEL_ADDRESS_WIDTH, NUM_BOIDS, BOX_SIZE.
  - Boid position struct {x[9:0], y[8:0]}.
  - FSM state enum {IDLE, ERASE, FETCH, CAPTURE, DRAW, DONE}.
- Sub-module box_scanner:
  - dx/dy counter with start/last flag, clip check, and address generation.
  - Instantiated once and shared by ERASE and DRAW.

Test Plan:
1. Reset, then hold screenEnd high 4 cycles; boid0=(10,20), others off-screen at (700,500). Expect writes of 1 at 12810, 12811, 13450, 13451 only; frame_done at cycle 321; exactly one frame started.
2. Second frame with boid0 moved to (11,20). Expect 0-writes to 12810, 12811, 13450, 13451, then 1-writes to 12811, 12812, 13451, 13452, in that order.
3. Edge clip with boid0=(639,479). Expect exactly one write, address 307199 data 1; the other 3 slots have pix_wr_en=0; total cycle count unchanged.
4. Second screenEnd rise at cycle 100 of a frame. Expect frame_dropped pulse for 1 cycle, frame_done still at 321, no restart.
5. Assert reset at cycle 50 of a frame. Expect pix_wr_en=0 and busy=0 on the following cycle. On the next frame the ERASE phase issues no writes (valid bits cleared).
6. First-frame erase check: in the first frame after reset, no 0-writes occur.
